// File: rtl/random_draw.sv
// rtl/random_draw.sv - draws COUNT distinct values in 0..max from an external counter-based generator
// Optional duplicate rejection via the used bitmap: RANDOM_DRAW_DUPCHECK_EN
module random_draw #(
    parameter int COUNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] max,
    input  logic       start,
    output logic [6:0] rnd_max,
    output logic       rnd_trigger,
    input  logic [6:0] rnd_value,
    output logic [6:0] val_out,
    output logic [6:0] val_idx,
    output logic       val_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, REQ, CHECK} state_e;

    localparam logic [7:0] COUNT_W  = 8'(COUNT);
    localparam logic [6:0] LAST_IDX = 7'(COUNT - 1);

    state_e     state_q, state_d;
    logic [6:0] max_q, max_d;
    logic [6:0] cnt_q, cnt_d;
    logic [6:0] val_q, val_d;
    logic [6:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic start_ok, in_range, dup, accept, last;

    // Widened to 8 bits so max=127 with COUNT=128 is still legal.
    assign start_ok = COUNT_W <= ({1'b0, max} + 8'd1);
    assign in_range = rnd_value <= max_q;
    assign last     = cnt_q == LAST_IDX;

`ifdef RANDOM_DRAW_DUPCHECK_EN
    logic [127:0] used_q, used_d;
    assign dup = used_q[rnd_value];
`else
    assign dup = 1'b0;
`endif

    assign accept = (state_q == CHECK) && in_range && !dup;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef RANDOM_DRAW_DUPCHECK_EN
        used_d  = used_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        max_d   = max;
                        cnt_d   = 7'd0;
`ifdef RANDOM_DRAW_DUPCHECK_EN
                        used_d  = '0;
`endif
                        state_d = REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            REQ:   state_d = CHECK;
            CHECK: begin
                state_d = REQ;
                if (accept) begin
`ifdef RANDOM_DRAW_DUPCHECK_EN
                    used_d[rnd_value] = 1'b1;
`endif
                    val_d   = rnd_value;
                    idx_d   = cnt_q;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 7'd1;
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            max_q   <= 7'd0;
            cnt_q   <= 7'd0;
            val_q   <= 7'd0;
            idx_q   <= 7'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef RANDOM_DRAW_DUPCHECK_EN
            used_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef RANDOM_DRAW_DUPCHECK_EN
            used_q  <= used_d;
`endif
        end
    end

    assign rnd_max     = max_q;
    assign rnd_trigger = state_q == REQ;
    assign busy        = state_q != IDLE;
    assign val_out     = val_q;
    assign val_idx     = idx_q;
    assign val_valid   = valid_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule

// File: doc/random_draw.md
# random_draw

Draws COUNT distinct values in 0..max by driving the trigger/max side of the counter-based random generator and consuming its 7-bit result. Duplicates and out-of-range samples are rejected and re-requested. Accepted values stream out with an index, for game/test logic that needs a shuffled sequence such as target positions. The block sits between the control FSM (start/done) and one random generator instance.

## Interface
- COUNT, 16, number of distinct values per run; legal range 1..128.
- clk  in  1  50 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- max  in  7  upper bound of the run, inclusive; sampled on accepted start.
- start  in  1  begins a run; sampled only in IDLE.
- rnd_max  out  7  latched max, wired to the generator's max input.
- rnd_trigger  out  1  generator sample request.
- rnd_value  in  7  generator output; valid the cycle after rnd_trigger.
- val_out  out  7  accepted value.
- val_idx  out  7  index of val_out, 0..COUNT-1.
- val_valid  out  1  one-cycle pulse per accepted value.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse at run completion.
- err  out  1  one-cycle pulse when a start is refused.

## Operation
- States: IDLE, REQ, CHECK.
- **IDLE**
  - On start with COUNT <= max+1: latch max into rnd_max, clear the used bitmap and draw counter, go to REQ.
  - On start with COUNT > max+1: pulse err, stay in IDLE, no trigger.
- **REQ**: rnd_trigger=1 for exactly one cycle, then go to CHECK.
- **CHECK**: evaluate rnd_value.
  - Reject if rnd_value > rnd_max, or if used[rnd_value]=1. On reject, go to REQ.
  - Otherwise accept: set used[rnd_value], register val_out=rnd_value and val_idx=draw counter, pulse val_valid, increment the counter.
  - After an accept, go to IDLE if it was draw COUNT-1 (done pulses with that val_valid), else go to REQ.
- busy = (state != IDLE).
- start while busy is ignored. max changes mid-run have no effect.
- The bitmap is 128 bits; index width is 7 bits. The counter never wraps within a run.
- val_out and val_idx hold their last values until the next accept.

## Timing
- Reset values: rnd_max=0, rnd_trigger=0, val_out=0, val_idx=0, val_valid=0, busy=0, done=0, err=0, state IDLE, bitmap cleared.
- start sampled at edge E: busy=1 and rnd_trigger=1 in the cycle after E.
- err pulses in the cycle after E; busy stays 0.
- Each draw takes at least 2 cycles (REQ + CHECK). Every rejection adds 2 cycles.
- val_valid is registered: it asserts the cycle after the CHECK that accepted.
- Minimum run length is 2*COUNT cycles plus 1 for the registered output.
- done coincides with the last val_valid. busy is 0 in that same cycle, so a new start is accepted in that cycle.
- rst asserted mid-run: all outputs return to reset values immediately; no done pulse.

## Configuration
- RANDOM_DRAW_DUPCHECK_EN
  - Defined: the used bitmap is built and duplicates are rejected as above.
  - Not defined: the bitmap is not synthesized and every in-range sample is accepted, so duplicates are possible.
  - Range rejection (rnd_value > rnd_max) and the err check stay active in both builds.

## Test plan
- COUNT=16, max=15, behavioural generator model: 16 val_valid pulses; values form a permutation of 0..15; val_idx runs 0..15; done coincides with idx 15; rnd_max=15 throughout.
- COUNT=16, max=9, start pulse: err=1 for one cycle; rnd_trigger, busy and done stay 0.
- COUNT=2, max=7, stub returning 3,3,3,5: outputs (3,idx0) and (5,idx1); exactly 4 rnd_trigger pulses; done with the second val_valid.
- COUNT=2, max=7, stub returning 12,1,2: 12 is rejected; outputs (1,idx0) and (2,idx1).
- COUNT=16, max=15: assert rst after the 5th val_valid → all outputs 0 immediately; a new start yields a complete 16-value run with val_idx starting at 0.
- Build without RANDOM_DRAW_DUPCHECK_EN, COUNT=2, stub returning 3,3: outputs (3,idx0) and (3,idx1). In a second start issued during busy: start is ignored and no err is raised.
